// File: rtl/pclk_gen.sv
// PCLK / symbol clock generator with glitch-free ratio switching and lock tracking.
// Optional lock settling counter enabled by defining LOCK_CNT_EN.
module pclk_gen #(
    parameter int CNT_W       = 8,
    parameter int DIV_SYM     = 10,
    parameter int LOCK_CYCLES = 64
) (
    input  logic             Ref_Clk,
    input  logic             RST_n,
    input  logic [5:0]       DataBusWidth,
    input  logic             Div_Override_En,
    input  logic [CNT_W-1:0] Div_Override,
    output logic             PCLK,
    output logic             Sym_Clk,
    output logic             PCLK_Rise,
    output logic             Ratio_Busy,
    output logic             Locked,
    output logic             Ratio_Err
);

    typedef enum logic [1:0] {
        LOCKING   = 2'd0,
        LOCKED    = 2'd1,
        SWITCHING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SYM_RATIO = CNT_W'(DIV_SYM);

    // Empty marker block: present in the elaborated hierarchy only for illegal parameter sets.
    if (DIV_SYM < 2 || LOCK_CYCLES < 1) begin : g_illegal_params
    end

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] req_ratio;
    logic             req_err;
    logic [CNT_W-1:0] ratio_reg;
    logic             ratio_valid_reg;
    logic [CNT_W-1:0] active_ratio;
    logic             load_ratio;
    logic [CNT_W-1:0] pclk_cnt_reg;
    logic             pclk_wrap;
    logic             pclk_reg;
    logic             pclk_rise_reg;
    logic [CNT_W-1:0] sym_cnt_reg;
    logic             sym_wrap;
    logic             sym_reg;
    logic             locked_reg;
    logic             busy_reg;
    logic             err_reg;
    logic             lock_done;

    // Requested ratio: bus-width decode, optionally replaced by the override.
    always_comb begin
        req_ratio = CNT_W'(10);
        req_err   = 1'b1;
        case (DataBusWidth)
            6'd8: begin
                req_ratio = CNT_W'(10);
                req_err   = 1'b0;
            end
            6'd16: begin
                req_ratio = CNT_W'(20);
                req_err   = 1'b0;
            end
            6'd32: begin
                req_ratio = CNT_W'(40);
                req_err   = 1'b0;
            end
            default: ;
        endcase
        if (Div_Override_En) begin
            if (Div_Override < CNT_W'(2)) begin
                req_ratio = CNT_W'(2);
                req_err   = 1'b1;
            end else begin
                req_ratio = Div_Override;
                req_err   = 1'b0;
            end
        end
    end

    // Until the first edge after reset the ratio register is stale, so the request is used directly.
    assign active_ratio = ratio_valid_reg ? ratio_reg : req_ratio;
    assign pclk_wrap    = (pclk_cnt_reg == active_ratio - CNT_W'(1));
    assign sym_wrap     = (sym_cnt_reg == SYM_RATIO - CNT_W'(1));
    assign load_ratio   = !ratio_valid_reg || ((state_reg == SWITCHING) && pclk_wrap);

`ifdef LOCK_CNT_EN
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    logic [LOCK_W-1:0] lock_cnt_reg;

    assign lock_done = (lock_cnt_reg == LOCK_W'(LOCK_CYCLES - 1));

    // Restarts from zero whenever LOCKING is (re)entered after a ratio load.
    always_ff @(posedge Ref_Clk or negedge RST_n) begin
        if (!RST_n) begin
            lock_cnt_reg <= '0;
        end else if ((state_reg == LOCKING) && !lock_done) begin
            lock_cnt_reg <= lock_cnt_reg + LOCK_W'(1);
        end else begin
            lock_cnt_reg <= '0;
        end
    end
`else
    assign lock_done = 1'b1;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOCKING: begin
                if (lock_done) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (req_ratio != active_ratio) begin
                    state_next = SWITCHING;
                end
            end
            SWITCHING: begin
                if (pclk_wrap) begin
                    state_next = LOCKING;
                end
            end
            default: state_next = LOCKING;
        endcase
    end

    always_ff @(posedge Ref_Clk or negedge RST_n) begin
        if (!RST_n) begin
            state_reg  <= LOCKING;
            locked_reg <= 1'b0;
            busy_reg   <= 1'b1;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            locked_reg <= (state_next == LOCKED);
            busy_reg   <= (state_next != LOCKED);
            err_reg    <= req_err;
        end
    end

    // New ratio only takes effect at a natural wrap, so the running period is never cut short.
    always_ff @(posedge Ref_Clk or negedge RST_n) begin
        if (!RST_n) begin
            pclk_cnt_reg    <= '0;
            pclk_reg        <= 1'b0;
            pclk_rise_reg   <= 1'b0;
            ratio_reg       <= CNT_W'(10);
            ratio_valid_reg <= 1'b0;
        end else begin
            pclk_reg        <= (pclk_cnt_reg < (active_ratio >> 1));
            pclk_rise_reg   <= (pclk_cnt_reg == '0);
            pclk_cnt_reg    <= pclk_wrap ? '0 : pclk_cnt_reg + CNT_W'(1);
            ratio_valid_reg <= 1'b1;
            if (load_ratio) begin
                ratio_reg <= req_ratio;
            end
        end
    end

    always_ff @(posedge Ref_Clk or negedge RST_n) begin
        if (!RST_n) begin
            sym_cnt_reg <= '0;
            sym_reg     <= 1'b0;
        end else begin
            sym_reg     <= (sym_cnt_reg < (SYM_RATIO >> 1));
            sym_cnt_reg <= sym_wrap ? '0 : sym_cnt_reg + CNT_W'(1);
        end
    end

    assign PCLK       = pclk_reg;
    assign PCLK_Rise  = pclk_rise_reg;
    assign Sym_Clk    = sym_reg;
    assign Locked     = locked_reg;
    assign Ratio_Busy = busy_reg;
    assign Ratio_Err  = err_reg;

endmodule
